// File: rtl/serial_adder_nbit.sv
// serial_adder_nbit: digit-serial WIDTH-bit adder/subtractor, DIGIT bits per cycle.
// Ports: clk, rst_n (async active-low); in_valid/in_ready with a, b, cin, sub;
//        out_valid/out_ready with sum, cout, ovf; busy is high while digits are summed.
module serial_adder_nbit #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             busy
);

    localparam int NUM_DIGITS = WIDTH / DIGIT;
    localparam int CW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CW-1:0] LAST = CW'(NUM_DIGITS - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic [WIDTH-1:0] psum;
    logic             carry;
    logic [CW-1:0]    cnt;

    logic [DIGIT:0]   dadd;
    logic [DIGIT-1:0] dsum;
    logic             dcarry;
    logic             msb_cin;
    logic [WIDTH-1:0] psum_next;
    logic             accept;
    logic             last;

    assign dadd   = {1'b0, opa[DIGIT-1:0]}
                  + {1'b0, opb[DIGIT-1:0]}
                  + {{DIGIT{1'b0}}, carry};
    assign dsum   = dadd[DIGIT-1:0];
    assign dcarry = dadd[DIGIT];

    // Carry into the top bit of this digit, recovered from the bit's own sum.
    // Only meaningful on the final digit, where that bit is the word MSB.
    assign msb_cin = opa[DIGIT-1] ^ opb[DIGIT-1] ^ dsum[DIGIT-1];

    // New digit enters at the top; after NUM_DIGITS shifts the word is aligned.
    assign psum_next = (psum >> DIGIT) | (WIDTH'(dsum) << (WIDTH - DIGIT));

    assign in_ready  = (state == S_IDLE) || ((state == S_DONE) && out_ready);
    assign accept    = in_valid && in_ready;
    assign last      = (cnt == LAST);
    assign busy      = (state == S_RUN);
    assign out_valid = (state == S_DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            opa   <= '0;
            opb   <= '0;
            psum  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: ;
                S_RUN: begin
                    opa   <= opa >> DIGIT;
                    opb   <= opb >> DIGIT;
                    psum  <= psum_next;
                    carry <= dcarry;
                    cnt   <= cnt + 1'b1;
                    if (last) begin
                        sum   <= psum_next;
                        cout  <= dcarry;
                        ovf   <= dcarry ^ msb_cin;
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase

            // Accept only happens in IDLE or DONE, so it never collides
            // with the RUN updates above; in DONE it overrides the IDLE exit.
            if (accept) begin
                opa   <= a;
                opb   <= sub ? ~b : b;
                carry <= sub ? 1'b1 : cin;
                cnt   <= '0;
                state <= S_RUN;
            end
        end
    end

endmodule

// File: tb/tb_serial_adder_nbit.sv
// tb_serial_adder_nbit: randomized + directed bench for serial_adder_nbit
// against an arithmetic reference model with a per-cycle compare process.
module tb_serial_adder_nbit;

    localparam int W  = 16;
    localparam int D  = 2;
    localparam int ND = W / D;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         busy;

    logic         iv16;
    logic         ir16;
    logic         ov16;
    logic         or16;
    logic [W-1:0] sum16;
    logic         cout16;
    logic         ovf16;
    logic         busy16;

    int checks = 0;
    int errors = 0;

    serial_adder_nbit #(.WIDTH(W), .DIGIT(D)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .ovf(ovf), .busy(busy)
    );

    serial_adder_nbit #(.WIDTH(W), .DIGIT(W)) u_dut16 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(iv16), .in_ready(ir16),
        .a(a), .b(b), .cin(cin), .sub(sub),
        .out_valid(ov16), .out_ready(or16),
        .sum(sum16), .cout(cout16), .ovf(ovf16), .busy(busy16)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: {ovf, cout, sum} from plain wide arithmetic.
    function automatic logic [W+1:0] ref_add(input logic [W-1:0] x,
                                             input logic [W-1:0] y,
                                             input logic c, input logic s);
        logic [W-1:0] yy;
        logic         ci;
        logic [W:0]   t;
        logic         v;
        yy = s ? ~y : y;
        ci = s ? 1'b1 : c;
        t  = {1'b0, x} + {1'b0, yy} + {{W{1'b0}}, ci};
        v  = (x[W-1] == yy[W-1]) && (t[W-1] != x[W-1]);
        return {v, t[W], t[W-1:0]};
    endfunction

    // Transaction-level model: edge count, one pending op, held result.
    int           cyc = 0;
    bit           m_pend = 0;
    int           m_done_at = 0;
    logic [W+1:0] m_res = '0;
    logic [W+1:0] m_hold = '0;

    initial begin
        bit rdy;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_pend = 0;
                m_hold = '0;
            end else begin
                cyc++;
                if (m_pend && cyc == m_done_at) m_hold = m_res;
                rdy = !m_pend || (cyc > m_done_at && out_ready);
                if (m_pend && cyc > m_done_at && out_ready) m_pend = 0;
                if (in_valid && rdy) begin
                    m_pend    = 1;
                    m_done_at = cyc + ND;
                    m_res     = ref_add(a, b, cin, sub);
                end
            end
        end
    end

    initial begin
        bit e_ov;
        bit e_busy;
        bit e_rdy;
        forever begin
            @(negedge clk);
            e_ov   = m_pend && cyc >= m_done_at;
            e_busy = m_pend && cyc < m_done_at;
            e_rdy  = !m_pend || (e_ov && out_ready);
            chk("out_valid", 32'(out_valid), 32'(e_ov));
            chk("busy", 32'(busy), 32'(e_busy));
            chk("in_ready", 32'(in_ready), 32'(e_rdy));
            chk("result", {14'd0, ovf, cout, sum}, {14'd0, m_hold});
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 5))
            0: return 16'h0000;
            1: return 16'hFFFF;
            2: return 16'h7FFF;
            3: return 16'h8000;
            default: return W'($urandom);
        endcase
    endfunction

    task automatic do_op(input logic [W-1:0] oa, input logic [W-1:0] ob,
                         input logic oc, input logic os,
                         input logic [W+1:0] exp, input string nm);
        int n;
        n = 0;
        while (!in_ready && n < 50) begin
            step();
            n++;
        end
        a = oa; b = ob; cin = oc; sub = os;
        in_valid = 1;
        step();
        in_valid = 0;
        n = 0;
        while (!out_valid && n < 50) begin
            a = W'($urandom); b = W'($urandom);
            sub = 1'($urandom); cin = 1'($urandom);
            step();
            n++;
        end
        chk({nm, " latency"}, n, ND);
        chk(nm, {14'd0, ovf, cout, sum}, {14'd0, exp});
        step();
    endtask

    initial begin
        clk = 0; rst_n = 0;
        in_valid = 0; out_ready = 1;
        a = '0; b = '0; cin = 0; sub = 0;
        iv16 = 0; or16 = 1;

        chk("ref 1234+4321", ref_add(16'h1234, 16'h4321, 0, 0), {2'b00, 16'h5555});
        chk("ref FFFF+1", ref_add(16'hFFFF, 16'h0001, 0, 0), {2'b01, 16'h0000});
        chk("ref 7FFF+1", ref_add(16'h7FFF, 16'h0001, 0, 0), {2'b10, 16'h8000});
        chk("ref 5-7", ref_add(16'h0005, 16'h0007, 1, 1), {2'b00, 16'hFFFE});
        chk("ref 8000-1", ref_add(16'h8000, 16'h0001, 1, 1), {2'b11, 16'h7FFF});

        repeat (2) @(posedge clk);
        #1;
        chk("rst in_ready", 32'(in_ready), 1);
        chk("rst out_valid", 32'(out_valid), 0);
        chk("rst busy", 32'(busy), 0);
        chk("rst sum", 32'(sum), 0);
        chk("rst cout/ovf", {30'd0, cout, ovf}, 0);
        rst_n = 1;
        step();

        // Plain add with explicit cycle-by-cycle timing.
        a = 16'h1234; b = 16'h4321; cin = 0; sub = 0;
        in_valid = 1;
        step();
        in_valid = 0;
        for (int i = 0; i < ND; i++) begin
            chk("t1 busy", 32'(busy), 1);
            chk("t1 no valid", 32'(out_valid), 0);
            step();
        end
        chk("t1 valid", 32'(out_valid), 1);
        chk("t1 result", {14'd0, ovf, cout, sum}, {16'd0, 16'h5555});
        step();

        // Single-cycle configuration.
        a = 16'h1234; b = 16'h4321; cin = 0; sub = 0;
        iv16 = 1;
        step();
        iv16 = 0;
        chk("w16 busy", 32'(busy16), 1);
        chk("w16 early", 32'(ov16), 0);
        step();
        chk("w16 valid", 32'(ov16), 1);
        chk("w16 result", {14'd0, ovf16, cout16, sum16}, {16'd0, 16'h5555});
        step();
        chk("w16 idle", 32'(ir16), 1);

        do_op(16'hFFFF, 16'h0001, 0, 0, {2'b01, 16'h0000}, "FFFF+1");
        do_op(16'h7FFF, 16'h0001, 0, 0, {2'b10, 16'h8000}, "7FFF+1");
        do_op(16'h0000, 16'h0000, 1, 0, {2'b00, 16'h0001}, "0+0+c");
        do_op(16'h0005, 16'h0007, 1, 1, {2'b00, 16'hFFFE}, "5-7");
        do_op(16'h8000, 16'h0001, 1, 1, {2'b11, 16'h7FFF}, "8000-1");

        // Backpressure with ignored requests, then back-to-back issue.
        out_ready = 0;
        a = 16'h1111; b = 16'h2222; cin = 0; sub = 0;
        in_valid = 1;
        step();
        for (int i = 0; i < ND; i++) begin
            in_valid = 1'($urandom);
            a = W'($urandom);
            step();
        end
        for (int i = 0; i < 5; i++) begin
            in_valid = 1;
            a = W'($urandom);
            step();
            chk("bp valid", 32'(out_valid), 1);
            chk("bp sum", {14'd0, ovf, cout, sum}, {16'd0, 16'h3333});
        end
        a = 16'h0001; b = 16'h0001; cin = 0; sub = 0;
        in_valid = 1; out_ready = 1;
        step();
        in_valid = 0;
        chk("b2b run", 32'(busy), 1);
        repeat (ND) step();
        chk("b2b valid", 32'(out_valid), 1);
        chk("b2b sum", 32'(sum), 32'h0002);
        step();

        // Asynchronous reset mid-run.
        a = 16'h1234; b = 16'h1111;
        in_valid = 1;
        step();
        in_valid = 0;
        repeat (3) step();
        #2;
        rst_n = 0;
        #1;
        chk("ar out_valid", 32'(out_valid), 0);
        chk("ar busy", 32'(busy), 0);
        chk("ar sum", 32'(sum), 0);
        chk("ar cout/ovf", {30'd0, cout, ovf}, 0);
        step();
        rst_n = 1;
        step();
        chk("ar in_ready", 32'(in_ready), 1);
        do_op(16'h00FF, 16'h0001, 0, 0, {2'b00, 16'h0100}, "after rst");

        // Random traffic with random backpressure.
        for (int i = 0; i < 600; i++) begin
            in_valid = 1'($urandom);
            a = pick(); b = pick();
            cin = 1'($urandom); sub = 1'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        in_valid = 0;
        out_ready = 1;
        repeat (20) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
